// File: rtl/fft_frame_sched.sv
// -----------------------------------------------------------------------------
// fft_frame_sched
//   Shares one fft_top instance between N_CH sample sources. An IDLE/STREAM/GAP
//   FSM grants one channel at a time (round-robin) and streams exactly FFT_LEN
//   contiguous samples into fft_top. The granted channel id is queued in a tag
//   FIFO so each serial result burst coming back from fft_top can be re-tagged
//   with its channel id plus start/end-of-frame markers.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   enable_i                permit new grants (a running frame always completes)
//   ch_req_i[N_CH]          channel k has a full frame ready
//   ch_re_i / ch_im_i       per-channel samples, slice k = [k*DATA_WID +: DATA_WID]
//   ch_rd_o[N_CH]           one-hot read strobe, sample consumed the same cycle
//   fft_re_o/fft_im_o/fft_val_o   registered sample stream to fft_top
//   fft_re_i/fft_im_i/fft_val_i   result stream from fft_top
//   out_re_o/out_im_o/out_val_o   registered, tagged result stream
//   out_ch_o, out_sop_o, out_eop_o  channel tag and frame markers
//   busy_o                  FSM active or frames still in flight
//   err_orphan_o            sticky: a result burst arrived with no tag queued
// -----------------------------------------------------------------------------
module fft_frame_sched #(
   parameter int DATA_WID  = 16,
   parameter int FFT_LEN   = 32,
   parameter int LOG2_LEN  = 5,
   parameter int N_CH      = 4,
   parameter int CH_W      = 2,
   parameter int GAP_CYC   = 1,
   parameter int TAG_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable_i,
   input  logic [N_CH-1:0]          ch_req_i,
   input  logic [N_CH*DATA_WID-1:0] ch_re_i,
   input  logic [N_CH*DATA_WID-1:0] ch_im_i,
   output logic [N_CH-1:0]          ch_rd_o,
   output logic [DATA_WID-1:0]      fft_re_o,
   output logic [DATA_WID-1:0]      fft_im_o,
   output logic                     fft_val_o,
   input  logic [DATA_WID-1:0]      fft_re_i,
   input  logic [DATA_WID-1:0]      fft_im_i,
   input  logic                     fft_val_i,
   output logic [DATA_WID-1:0]      out_re_o,
   output logic [DATA_WID-1:0]      out_im_o,
   output logic                     out_val_o,
   output logic [CH_W-1:0]          out_ch_o,
   output logic                     out_sop_o,
   output logic                     out_eop_o,
   output logic                     busy_o,
   output logic                     err_orphan_o
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_GAP    = 2'd2;

   localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   localparam logic [LOG2_LEN-1:0] LAST_IDX = LOG2_LEN'(FFT_LEN - 1);
   localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_CYC - 1);
   localparam logic [TAG_AW:0]     TAG_FULL = (TAG_AW+1)'(TAG_DEPTH);
   localparam logic [TAG_AW-1:0]   TAG_TOP  = TAG_AW'(TAG_DEPTH - 1);
   localparam logic [CH_W-1:0]     CH_TOP   = CH_W'(N_CH - 1);

   // ---------------------------------------------------------------- state
   logic [1:0]          state_q, state_d;
   logic [CH_W-1:0]     gnt_q, gnt_d;
   logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [LOG2_LEN-1:0] in_cnt_q, in_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

   logic [DATA_WID-1:0] fft_re_q, fft_re_d;
   logic [DATA_WID-1:0] fft_im_q, fft_im_d;
   logic                fft_val_q, fft_val_d;

   logic [CH_W-1:0]     tag_mem_q [TAG_DEPTH];
   logic [CH_W-1:0]     tag_mem_d [TAG_DEPTH];
   logic [TAG_AW-1:0]   tag_wr_q, tag_wr_d;
   logic [TAG_AW-1:0]   tag_rd_q, tag_rd_d;
   logic [TAG_AW:0]     tag_cnt_q, tag_cnt_d;

   logic [LOG2_LEN-1:0] out_cnt_q, out_cnt_d;
   logic                orph_burst_q, orph_burst_d;
   logic                err_q, err_d;
   logic [DATA_WID-1:0] out_re_q, out_re_d;
   logic [DATA_WID-1:0] out_im_q, out_im_d;
   logic                out_val_q, out_val_d;
   logic [CH_W-1:0]     out_ch_q, out_ch_d;
   logic                out_sop_q, out_sop_d;
   logic                out_eop_q, out_eop_d;

   logic                tag_empty, tag_full, tag_push, tag_pop;
   logic                start, burst_orph;
   logic                arb_found;
   logic [CH_W-1:0]     arb_win;
   int                  arb_idx;

   assign tag_empty = (tag_cnt_q == '0);
   assign tag_full  = (tag_cnt_q == TAG_FULL);

   function automatic logic [TAG_AW-1:0] tag_inc(input logic [TAG_AW-1:0] p);
      return (p == TAG_TOP) ? '0 : p + TAG_AW'(1);
   endfunction

   // ------------------------------------------------------------- arbiter
   // First requester at or after rr_ptr, wrapping around the channel ring.
   always_comb begin
      arb_found = 1'b0;
      arb_win   = '0;
      arb_idx   = 0;
      for (int i = 0; i < N_CH; i++) begin
         arb_idx = (int'(rr_ptr_q) + i) % N_CH;
         if (!arb_found && ch_req_i[CH_W'(arb_idx)]) begin
            arb_found = 1'b1;
            arb_win   = CH_W'(arb_idx);
         end
      end
   end

   // A tag slot must be free before a frame is granted, so the FIFO never
   // overflows even if fft_top stalls its output indefinitely.
   assign start = (state_q == ST_IDLE) && enable_i && arb_found && !tag_full;

   // ----------------------------------------------------------------- FSM
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      rr_ptr_d  = rr_ptr_q;
      in_cnt_d  = in_cnt_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               gnt_d    = arb_win;
               rr_ptr_d = (arb_win == CH_TOP) ? '0 : arb_win + CH_W'(1);
               in_cnt_d = '0;
               state_d  = ST_STREAM;
            end
         end
         ST_STREAM: begin
            in_cnt_d = in_cnt_q + LOG2_LEN'(1);
            if (in_cnt_q == LAST_IDX) begin
               in_cnt_d  = '0;
               gap_cnt_d = '0;
               state_d   = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = '0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ch_rd_o = '0;
      if (state_q == ST_STREAM) ch_rd_o[gnt_q] = 1'b1;
   end

   // ---------------------------------------------------------- input path
   always_comb begin
      fft_val_d = (state_q == ST_STREAM);
      fft_re_d  = '0;
      fft_im_d  = '0;
      if (state_q == ST_STREAM) begin
         fft_re_d = ch_re_i[int'(gnt_q)*DATA_WID +: DATA_WID];
         fft_im_d = ch_im_i[int'(gnt_q)*DATA_WID +: DATA_WID];
      end
   end

   // --------------------------------------------------- output path + tags
   // A burst is classified on its first bin: with no tag queued it is an
   // orphan, and that decision sticks for the rest of the burst.
   assign burst_orph = (out_cnt_q == '0) ? tag_empty : orph_burst_q;
   assign tag_push   = start;
   assign tag_pop    = fft_val_i && !burst_orph && (out_cnt_q == LAST_IDX);

   always_comb begin
      out_cnt_d    = out_cnt_q;
      orph_burst_d = orph_burst_q;
      err_d        = err_q;
      out_val_d    = fft_val_i && !burst_orph;
      out_re_d     = '0;
      out_im_d     = '0;
      out_ch_d     = '0;
      out_sop_d    = 1'b0;
      out_eop_d    = 1'b0;
      if (fft_val_i) begin
         out_cnt_d    = (out_cnt_q == LAST_IDX) ? '0 : out_cnt_q + LOG2_LEN'(1);
         orph_burst_d = burst_orph;
         if (out_cnt_q == '0 && tag_empty) err_d = 1'b1;
      end
      if (out_val_d) begin
         out_re_d  = fft_re_i;
         out_im_d  = fft_im_i;
         out_ch_d  = tag_mem_q[tag_rd_q];
         out_sop_d = (out_cnt_q == '0);
         out_eop_d = (out_cnt_q == LAST_IDX);
      end
   end

   always_comb begin
      tag_mem_d = tag_mem_q;
      tag_wr_d  = tag_wr_q;
      tag_rd_d  = tag_rd_q;
      tag_cnt_d = tag_cnt_q;
      if (tag_push) begin
         tag_mem_d[tag_wr_q] = arb_win;
         tag_wr_d            = tag_inc(tag_wr_q);
      end
      if (tag_pop) tag_rd_d = tag_inc(tag_rd_q);
      case ({tag_push, tag_pop})
         2'b10:   tag_cnt_d = tag_cnt_q + (TAG_AW+1)'(1);
         2'b01:   tag_cnt_d = tag_cnt_q - (TAG_AW+1)'(1);
         default: tag_cnt_d = tag_cnt_q;
      endcase
   end

   // ---------------------------------------------------------------- flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         gnt_q        <= '0;
         rr_ptr_q     <= '0;
         in_cnt_q     <= '0;
         gap_cnt_q    <= '0;
         fft_re_q     <= '0;
         fft_im_q     <= '0;
         fft_val_q    <= 1'b0;
         for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
         tag_wr_q     <= '0;
         tag_rd_q     <= '0;
         tag_cnt_q    <= '0;
         out_cnt_q    <= '0;
         orph_burst_q <= 1'b0;
         err_q        <= 1'b0;
         out_re_q     <= '0;
         out_im_q     <= '0;
         out_val_q    <= 1'b0;
         out_ch_q     <= '0;
         out_sop_q    <= 1'b0;
         out_eop_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         rr_ptr_q     <= rr_ptr_d;
         in_cnt_q     <= in_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         fft_re_q     <= fft_re_d;
         fft_im_q     <= fft_im_d;
         fft_val_q    <= fft_val_d;
         tag_mem_q    <= tag_mem_d;
         tag_wr_q     <= tag_wr_d;
         tag_rd_q     <= tag_rd_d;
         tag_cnt_q    <= tag_cnt_d;
         out_cnt_q    <= out_cnt_d;
         orph_burst_q <= orph_burst_d;
         err_q        <= err_d;
         out_re_q     <= out_re_d;
         out_im_q     <= out_im_d;
         out_val_q    <= out_val_d;
         out_ch_q     <= out_ch_d;
         out_sop_q    <= out_sop_d;
         out_eop_q    <= out_eop_d;
      end
   end

   assign fft_re_o     = fft_re_q;
   assign fft_im_o     = fft_im_q;
   assign fft_val_o    = fft_val_q;
   assign out_re_o     = out_re_q;
   assign out_im_o     = out_im_q;
   assign out_val_o    = out_val_q;
   assign out_ch_o     = out_ch_q;
   assign out_sop_o    = out_sop_q;
   assign out_eop_o    = out_eop_q;
   assign err_orphan_o = err_q;
   assign busy_o       = (state_q != ST_IDLE) || !tag_empty;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched. Sources are modelled as per-channel sample
// counters, fft_top as a stub that buffers whole frames and replays them with
// a fixed transform (re+3, im^0x00ff) after a random gap. A frame-level
// reference model predicts round-robin grants and pushes the expected tagged
// result beats; independent monitors pop and compare.
module tb_fft_frame_sched;
   localparam int DW = 16, LEN = 32, LG = 5, NCH = 4, CW = 2, GAP = 1, TD = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                enable_i;
   logic [NCH-1:0]      ch_req_i;
   logic [NCH*DW-1:0]   ch_re_i = '0;
   logic [NCH*DW-1:0]   ch_im_i = '0;
   logic [NCH-1:0]      ch_rd_o;
   logic [DW-1:0]       fft_re_o, fft_im_o;
   logic                fft_val_o;
   logic [DW-1:0]       fft_re_i = '0;
   logic [DW-1:0]       fft_im_i = '0;
   logic                fft_val_i = 1'b0;
   logic [DW-1:0]       out_re_o, out_im_o;
   logic                out_val_o;
   logic [CW-1:0]       out_ch_o;
   logic                out_sop_o, out_eop_o, busy_o, err_orphan_o;

   fft_frame_sched #(.DATA_WID(DW), .FFT_LEN(LEN), .LOG2_LEN(LG), .N_CH(NCH),
                     .CH_W(CW), .GAP_CYC(GAP), .TAG_DEPTH(TD)) dut (
      .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .ch_req_i(ch_req_i),
      .ch_re_i(ch_re_i), .ch_im_i(ch_im_i), .ch_rd_o(ch_rd_o),
      .fft_re_o(fft_re_o), .fft_im_o(fft_im_o), .fft_val_o(fft_val_o),
      .fft_re_i(fft_re_i), .fft_im_i(fft_im_i), .fft_val_i(fft_val_i),
      .out_re_o(out_re_o), .out_im_o(out_im_o), .out_val_o(out_val_o),
      .out_ch_o(out_ch_o), .out_sop_o(out_sop_o), .out_eop_o(out_eop_o),
      .busy_o(busy_o), .err_orphan_o(err_orphan_o));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CW-1:0] ch;
      logic          sop;
      logic          eop;
      logic [DW-1:0] re;
      logic [DW-1:0] im;
   } beat_t;

   int pass_cnt = 0, tot_cnt = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
   endfunction

   function automatic logic [DW-1:0] src_re(int k, int unsigned p);
      return DW'(k * 4096 + int'(p));
   endfunction

   // ------------------------------------------------ reference model state
   beat_t            exp_out[$];
   logic [2*DW-1:0]  exp_in[$];
   int unsigned      ptr[NCH];
   logic [NCH-1:0]   prev_rd = '0, req_prev = '0;
   int               run_len = 0, rr_m = 0, grants = 0, last_rise = -1;
   bit               exact_sp = 0, prev_exact = 0;

   initial for (int k = 0; k < NCH; k++) ptr[k] = 0;

   // Source model + grant predictor.
   always @(negedge clk) begin
      for (int k = 0; k < NCH; k++) if (prev_rd[k]) ptr[k] = ptr[k] + 1;
      if (!rst_n) begin
         exp_out.delete();
         exp_in.delete();
         run_len = 0; rr_m = 0; last_rise = -1; prev_exact = 0;
         prev_rd = '0;
      end else begin
         if (ch_rd_o != '0 && prev_rd == '0) begin
            int w;
            w = -1;
            for (int i = 0; i < NCH; i++)
               if (w < 0 && req_prev[(rr_m + i) % NCH]) w = (rr_m + i) % NCH;
            if (w < 0) w = 0;
            chk("grant_onehot", 64'(ch_rd_o), 64'(1) << w);
            if (last_rise >= 0) begin
               chk("frame_spacing_min", 64'(cyc - last_rise >= LEN + 1 + GAP), 64'd1);
               if (exact_sp && prev_exact) chk("frame_spacing", 64'(cyc - last_rise), 64'(LEN + 1 + GAP));
            end
            last_rise = cyc; prev_exact = exact_sp;
            rr_m = (w + 1) % NCH;
            grants++;
            for (int i = 0; i < LEN; i++) begin
               beat_t b;
               logic [DW-1:0] r;
               r = src_re(w, ptr[w] + i);
               b.ch = CW'(w); b.sop = (i == 0); b.eop = (i == LEN - 1);
               b.re = r + DW'(3); b.im = (~r) ^ 16'h00ff;
               exp_out.push_back(b);
            end
         end
         if (ch_rd_o != '0) begin
            run_len++;
            for (int k = 0; k < NCH; k++)
               if (ch_rd_o[k]) exp_in.push_back({src_re(k, ptr[k]), ~src_re(k, ptr[k])});
         end else if (run_len > 0) begin
            chk("rd_run_len", 64'(run_len), 64'(LEN));
            run_len = 0;
         end
         prev_rd = ch_rd_o;
      end
      req_prev = ch_req_i;
      for (int k = 0; k < NCH; k++) begin
         ch_re_i[k*DW +: DW] = src_re(k, ptr[k]);
         ch_im_i[k*DW +: DW] = ~src_re(k, ptr[k]);
      end
   end

   // fft_top stub: buffer complete frames, replay when not held.
   logic [2*DW-1:0] stub_q[$];
   int  stub_fill = 0, frames_ready = 0, emit_left = 0, gap_left = 0;
   int  inject_cnt = 0, inject_done = 0;
   bit  orph_mode = 0, stub_hold = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         stub_q.delete();
         stub_fill = 0; frames_ready = 0; emit_left = 0; gap_left = 0;
         fft_val_i = 1'b0; fft_re_i = '0; fft_im_i = '0;
      end else begin
         if (fft_val_o) begin
            stub_q.push_back({fft_re_o, fft_im_o});
            stub_fill++;
            if (stub_fill == LEN) begin stub_fill = 0; frames_ready++; end
         end
         if (emit_left == 0 && gap_left == 0) begin
            if (!stub_hold && frames_ready > 0) begin
               emit_left = LEN; orph_mode = 0; frames_ready--;
            end else if (inject_cnt > inject_done) begin
               inject_done++; emit_left = LEN; orph_mode = 1;
            end
         end
         if (emit_left > 0) begin
            fft_val_i = 1'b1;
            if (orph_mode) begin
               fft_re_i = DW'($urandom); fft_im_i = DW'($urandom);
            end else begin
               logic [2*DW-1:0] s;
               s = stub_q.pop_front();
               fft_re_i = s[2*DW-1:DW] + DW'(3);
               fft_im_i = s[DW-1:0] ^ 16'h00ff;
            end
            emit_left--;
            if (emit_left == 0) gap_left = $urandom_range(0, 2);
         end else begin
            fft_val_i = 1'b0; fft_re_i = '0; fft_im_i = '0;
            if (gap_left > 0) gap_left--;
         end
      end
   end

   // Monitor: fft_top input stream.
   always @(negedge clk) begin
      if (rst_n) begin
         if (fft_val_o) begin
            if (exp_in.size() == 0) chk("fft_in_unexpected", 64'd1, 64'd0);
            else chk("fft_in_data", 64'({fft_re_o, fft_im_o}), 64'(exp_in.pop_front()));
         end else if (fft_re_o != '0 || fft_im_o != '0) begin
            chk("fft_in_idle_zero", 64'({fft_re_o, fft_im_o}), 64'd0);
         end
      end
   end

   // Monitor: tagged result stream.
   always @(negedge clk) begin
      if (rst_n && out_val_o) begin
         if (exp_out.size() == 0) chk("out_unexpected", 64'd1, 64'd0);
         else chk("out_beat", 64'({out_ch_o, out_sop_o, out_eop_o, out_re_o, out_im_o}),
                  64'(exp_out.pop_front()));
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_grants(input int target, input int budget, input string nm);
      int n = 0;
      while (grants < target && n < budget) begin @(posedge clk); n++; end
      #2;
      chk(nm, 64'(grants >= target), 64'd1);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((exp_out.size() != 0 || busy_o || frames_ready != 0 || emit_left != 0) && n < 1500) begin
         @(posedge clk); n++;
      end
      step(2);
      chk(nm, 64'(exp_out.size() == 0 && !busy_o), 64'd1);
   endtask

   task automatic wait_run(input int len);
      int n = 0;
      while (run_len != len && n < 400) begin @(posedge clk); n++; end
      #2;
      chk("wait_run_len", 64'(run_len), 64'(len));
   endtask

   initial begin
      int g0;
      rst_n = 1'b0; enable_i = 1'b0; ch_req_i = '0;
      step(3);
      chk("rst_outs_a", 64'({ch_rd_o, fft_val_o, fft_re_o, fft_im_o, out_val_o}), 64'd0);
      chk("rst_outs_b", 64'({out_re_o, out_im_o, out_ch_o, out_sop_o, out_eop_o, busy_o, err_orphan_o}), 64'd0);
      rst_n = 1'b1;
      step(2);

      // Single-channel frame from ch2.
      enable_i = 1'b1; ch_req_i = 4'b0100;
      wait_grants(1, 50, "t1_grant");
      ch_req_i = '0;
      drain("t1_drain");

      // All channels requesting: strict rotation, fixed frame spacing.
      exact_sp = 1; g0 = grants; ch_req_i = 4'b1111;
      wait_grants(g0 + 5, 400, "t2_grants");
      exact_sp = 0; ch_req_i = '0;
      drain("t2_drain");

      // Stalled fft_top: tag FIFO depth limits frames in flight.
      stub_hold = 1; g0 = grants; ch_req_i = 4'b1111;
      step(400);
      chk("stall_grants", 64'(grants - g0), 64'(TD));
      chk("stall_rd_idle", 64'(ch_rd_o), 64'd0);
      chk("stall_busy", 64'(busy_o), 64'd1);
      stub_hold = 0;
      wait_grants(g0 + TD + 1, 200, "stall_resume");
      ch_req_i = '0;
      drain("stall_drain");

      // Randomized request/enable traffic.
      for (int it = 0; it < 25; it++) begin
         ch_req_i = NCH'($urandom_range(0, 15));
         enable_i = ($urandom_range(0, 9) != 0);
         step($urandom_range(10, 80));
      end
      ch_req_i = '0; enable_i = 1'b1;
      drain("rand_drain");

      // enable_i dropped mid-frame: frame completes, no new grant.
      ch_req_i = 4'b0001;
      wait_run(11);
      enable_i = 1'b0; g0 = grants;
      step(200);
      chk("en_drop_no_grant", 64'(grants), 64'(g0));
      drain("en_drop_drain");
      chk("en_drop_busy", 64'(busy_o), 64'd0);
      ch_req_i = '0; enable_i = 1'b1;

      // Reset mid-frame.
      ch_req_i = 4'b0010;
      wait_run(15);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_a", 64'({ch_rd_o, fft_val_o, fft_re_o, fft_im_o, out_val_o}), 64'd0);
      chk("mid_rst_b", 64'({out_re_o, out_im_o, out_ch_o, out_sop_o, out_eop_o, busy_o, err_orphan_o}), 64'd0);
      ch_req_i = '0;
      step(3);
      rst_n = 1'b1;
      step(2);

      // Orphan burst with empty tag FIFO.
      inject_cnt++;
      step(60);
      chk("orphan_err", 64'(err_orphan_o), 64'd1);
      chk("orphan_no_busy", 64'(busy_o), 64'd0);

      // Clean frame after reset: rr pointer back at 0.
      g0 = grants; ch_req_i = 4'b0001;
      wait_grants(g0 + 1, 50, "post_rst_grant");
      ch_req_i = '0;
      drain("post_rst_drain");
      chk("orphan_sticky", 64'(err_orphan_o), 64'd1);
      chk("fft_in_q_empty", 64'(exp_in.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
      $fatal(1, "watchdog");
   end
endmodule
